// File: rtl/mult_div_pkg.sv
// Shared types for the sequential multiply/divide unit: FSM states, op encoding,
// and the fixed iteration count (one result bit per cycle).
package mult_div_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_t;

endpackage

// File: rtl/mult_div_if.sv
// Start/operand/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_if #(
  parameter int WIDTH = 32
);

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {P, Q, q_1} register: conditional add/sub
// of M into P, then a one-bit arithmetic right shift of the whole register.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_in,
  input  logic [WIDTH-1:0] m,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH:0]   sum;

  assign p   = acc_in[2*WIDTH:WIDTH+1];
  assign q   = acc_in[WIDTH:1];
  assign q_1 = acc_in[0];

  // P is widened by one sign bit so that P - M cannot overflow when M is the
  // most negative value; the shift then folds that extra bit back into P.
  always_comb begin
    sum = {p[WIDTH-1], p};
    case ({q[0], q_1})
      2'b01:   sum = {p[WIDTH-1], p} + {m[WIDTH-1], m};
      2'b10:   sum = {p[WIDTH-1], p} - {m[WIDTH-1], m};
      default: sum = {p[WIDTH-1], p};
    endcase
  end

  assign acc_out = {sum, q};

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (Booth) / divide (restoring) unit producing HI/LO
// for the multicycle MIPS datapath; one bit per cycle, 34-edge latency.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  localparam int              CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t           state;
  state_t           next_state;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             q_1;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             done_reg;
  logic             dz_reg;
  logic             accept;
  logic [2*WIDTH:0] booth_next;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // The done cycle still counts as busy, so a new op can only start once done drops.
  assign accept = (state == IDLE) && !done_reg && (bus.start_mult || bus.start_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!bus.start_mult && (bus.b == '0)) next_state = FINISH;
          else                                  next_state = RUN;
        end
      end
      RUN:     if (cnt == LAST) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc_in  ({p_reg, q_reg, q_1}),
    .m       (m_reg),
    .acc_out (booth_next)
  );

  // Restoring divide step; R stays below |b| <= 2^(WIDTH-1), so its top bit is
  // always zero and the shifted remainder still fits in WIDTH bits.
  always_comb begin
    r_shift = {p_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    r_diff  = {1'b0, r_shift} - {1'b0, m_reg};
    r_next  = r_shift;
    q_next  = {q_reg[WIDTH-2:0], 1'b0};
    if (!r_diff[WIDTH]) begin
      r_next = r_diff[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end
  end

  assign abs_a   = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign abs_b   = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign q_final = neg_q ? (~q_reg + 1'b1) : q_reg;
  assign r_final = neg_r ? (~p_reg + 1'b1) : p_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op       <= OP_MULT;
      cnt      <= '0;
      p_reg    <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      q_1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            p_reg <= '0;
            q_1   <= 1'b0;
            if (bus.start_mult) begin
              op    <= OP_MULT;
              q_reg <= bus.a;
              m_reg <= bus.b;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b0;
            end else begin
              op    <= OP_DIV;
              q_reg <= abs_a;
              m_reg <= abs_b;
              neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r <= bus.a[WIDTH-1];
              dz    <= (bus.b == '0);
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op == OP_MULT) {p_reg, q_reg, q_1} <= booth_next;
          else               {p_reg, q_reg}      <= {r_next, q_next};
        end
        FINISH: begin
          done_reg <= 1'b1;
          if (dz) begin
            dz_reg <= 1'b1;
          end else if (op == OP_MULT) begin
            hi_reg <= p_reg;
            lo_reg <= q_reg;
          end else begin
            hi_reg <= r_final;
            lo_reg <= q_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = dz_reg;
  assign bus.busy     = (state != IDLE) || done_reg;

endmodule
